// File: rtl/garage_door_ctrl_timed.sv
// Garage door controller: edge-triggered button, stop/reverse, obstacle reversal, travel timeout and auto-close.
// Motor outputs and Fault are registered from the next state, so a press sampled at edge k drives the motor right after edge k.
module garage_door_ctrl_timed #(
   parameter int TRAVEL_TIMEOUT = 1000,
   parameter int AUTO_CLOSE     = 0,
   parameter int CNT_W          = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       UP_Max,
   input  logic       DN_Max,
   input  logic       Activate,
   input  logic       Obstacle,
   output logic       UP_M,
   output logic       DN_M,
   output logic       Fault,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MV_UP   = 3'd1,
      S_MV_DN   = 3'd2,
      S_OPEN    = 3'd3,
      S_STOPPED = 3'd4,
      S_FAULT   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] AC_LAST = CNT_W'((AUTO_CLOSE > 0) ? (AUTO_CLOSE - 1) : 0);
   localparam bit               AC_EN   = (AUTO_CLOSE != 0);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               act_q;
   logic               last_up_q, last_up_d;
   logic               up_m_q, dn_m_q, fault_q;
   logic               press;
   logic               sensor_err;
   logic               timeout;
   logic [CNT_W-1:0]   cnt_inc;

   assign press      = Activate & ~act_q;
   assign sensor_err = UP_Max & DN_Max;
   assign timeout    = (cnt_q == TO_LAST);
   assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

   // Branch order inside each state encodes: sensor fault > limit > obstacle > press > timer.
   always_comb begin
      state_d   = state_q;
      last_up_d = last_up_q;
      if (state_q != S_FAULT && sensor_err) begin
         state_d = S_FAULT;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (press) state_d = UP_Max ? S_MV_DN : S_MV_UP;
            end
            S_MV_UP: begin
               if (UP_Max) begin
                  state_d = S_OPEN;
               end else if (press) begin
                  state_d   = S_STOPPED;
                  last_up_d = 1'b1;
               end else if (timeout) begin
                  state_d = S_FAULT;
               end
            end
            S_MV_DN: begin
               if (DN_Max) begin
                  state_d = S_IDLE;
               end else if (Obstacle) begin
                  state_d = S_MV_UP;
               end else if (press) begin
                  state_d   = S_STOPPED;
                  last_up_d = 1'b0;
               end else if (timeout) begin
                  state_d = S_FAULT;
               end
            end
            S_OPEN: begin
               if (press) begin
                  state_d = S_MV_DN;
               end else if (AC_EN && (cnt_q == AC_LAST) && !Obstacle) begin
                  state_d = S_MV_DN;
               end
            end
            S_STOPPED: begin
               if (press) state_d = last_up_q ? S_MV_DN : S_MV_UP;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Any state change restarts the count, which also gives a reversal a fresh timeout window.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else begin
         case (state_q)
            S_MV_UP, S_MV_DN: cnt_d = cnt_inc;
            S_OPEN:           cnt_d = Obstacle ? '0 : cnt_inc;
            default:          cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         act_q     <= 1'b0;
         last_up_q <= 1'b0;
         up_m_q    <= 1'b0;
         dn_m_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         act_q     <= Activate;
         last_up_q <= last_up_d;
         up_m_q    <= (state_d == S_MV_UP);
         dn_m_q    <= (state_d == S_MV_DN);
         fault_q   <= (state_d == S_FAULT);
      end
   end

   assign UP_M  = up_m_q;
   assign DN_M  = dn_m_q;
   assign Fault = fault_q;
   assign State = state_q;

endmodule

// File: tb/tb_garage_door_ctrl_timed.sv
// Directed bench: instance a (TRAVEL_TIMEOUT=8, no auto-close), instance b (TRAVEL_TIMEOUT=8, AUTO_CLOSE=5).
module tb_garage_door_ctrl_timed;

   logic CLK, RST;
   logic a_up, a_dn, a_act, a_obs, a_upm, a_dnm, a_flt;
   logic b_up, b_dn, b_act, b_obs, b_upm, b_dnm, b_flt;
   logic [2:0] a_st, b_st;
   int passed = 0;
   int total  = 0;

   garage_door_ctrl_timed #(.TRAVEL_TIMEOUT(8), .AUTO_CLOSE(0), .CNT_W(16)) dut_a (
      .CLK(CLK), .RST(RST), .UP_Max(a_up), .DN_Max(a_dn), .Activate(a_act), .Obstacle(a_obs),
      .UP_M(a_upm), .DN_M(a_dnm), .Fault(a_flt), .State(a_st));

   garage_door_ctrl_timed #(.TRAVEL_TIMEOUT(8), .AUTO_CLOSE(5), .CNT_W(16)) dut_b (
      .CLK(CLK), .RST(RST), .UP_Max(b_up), .DN_Max(b_dn), .Activate(b_act), .Obstacle(b_obs),
      .UP_M(b_upm), .DN_M(b_dnm), .Fault(b_flt), .State(b_st));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b0;
      a_up = 1'b0; a_dn = 1'b1; a_act = 1'b0; a_obs = 1'b0;
      b_up = 1'b0; b_dn = 1'b1; b_act = 1'b0; b_obs = 1'b0;
      step();
      step();
      RST = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      total++; if (a_upm !== 1'b0) $display("FAIL reset_up_m: got %b want 0", a_upm); else passed++;
      total++; if (a_dnm !== 1'b0) $display("FAIL reset_dn_m: got %b want 0", a_dnm); else passed++;
      total++; if (a_flt !== 1'b0) $display("FAIL reset_fault: got %b want 0", a_flt); else passed++;
      total++; if (a_st !== 3'd0) $display("FAIL reset_state: got %0d want 0", a_st); else passed++;
      total++; if (b_st !== 3'd0) $display("FAIL reset_state_b: got %0d want 0", b_st); else passed++;
   endtask

   task automatic test_open_and_hold();
      int n;
      do_reset();
      a_act = 1'b1;
      step();
      total++; if (a_upm !== 1'b1) $display("FAIL open_up_m: got %b want 1", a_upm); else passed++;
      total++; if (a_st !== 3'd1) $display("FAIL open_state_mv_up: got %0d want 1", a_st); else passed++;
      a_act = 1'b0; a_dn = 1'b0;
      step();
      step();
      a_up = 1'b1;
      step();
      total++; if (a_upm !== 1'b0) $display("FAIL open_up_m_off: got %b want 0", a_upm); else passed++;
      total++; if (a_st !== 3'd3) $display("FAIL open_state_open: got %0d want 3", a_st); else passed++;
      a_act = 1'b1; a_up = 1'b0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (a_dnm === 1'b1) n++;
      end
      total++; if (n !== 5) $display("FAIL hold_dn_m_cycles: got %0d want 5", n); else passed++;
      total++; if (a_st !== 3'd2) $display("FAIL hold_state: got %0d want 2", a_st); else passed++;
      a_act = 1'b0; a_dn = 1'b1;
      step();
      total++; if (a_st !== 3'd0) $display("FAIL closed_state: got %0d want 0", a_st); else passed++;
      total++; if (a_dnm !== 1'b0) $display("FAIL closed_dn_m: got %b want 0", a_dnm); else passed++;
   endtask

   task automatic test_obstacle();
      do_reset();
      a_dn = 1'b0; a_up = 1'b1; a_act = 1'b1;
      step();
      total++; if (a_dnm !== 1'b1) $display("FAIL obs_start_dn_m: got %b want 1", a_dnm); else passed++;
      a_act = 1'b0; a_up = 1'b0;
      step();
      a_obs = 1'b1;
      step();
      total++; if (a_dnm !== 1'b0) $display("FAIL obs_dn_m: got %b want 0", a_dnm); else passed++;
      total++; if (a_upm !== 1'b1) $display("FAIL obs_up_m: got %b want 1", a_upm); else passed++;
      a_obs = 1'b0; a_up = 1'b1;
      step();
      total++; if (a_st !== 3'd3) $display("FAIL obs_reopen_state: got %0d want 3", a_st); else passed++;
      a_act = 1'b1;
      step();
      a_act = 1'b0; a_up = 1'b0;
      step();
      a_obs = 1'b1; a_act = 1'b1;
      step();
      total++; if (a_st !== 3'd1) $display("FAIL obs_press_state: got %0d want 1", a_st); else passed++;
      total++; if (a_upm !== 1'b1) $display("FAIL obs_press_up_m: got %b want 1", a_upm); else passed++;
      a_obs = 1'b0; a_act = 1'b0;
      step();
   endtask

   task automatic test_stop_reverse();
      do_reset();
      a_act = 1'b1;
      step();
      a_act = 1'b0; a_dn = 1'b0;
      step();
      a_act = 1'b1;
      step();
      total++; if (a_upm !== 1'b0) $display("FAIL stop_up_m: got %b want 0", a_upm); else passed++;
      total++; if (a_st !== 3'd4) $display("FAIL stop_state: got %0d want 4", a_st); else passed++;
      a_act = 1'b0;
      step();
      total++; if (a_st !== 3'd4) $display("FAIL stop_hold_state: got %0d want 4", a_st); else passed++;
      a_act = 1'b1;
      step();
      total++; if (a_dnm !== 1'b1) $display("FAIL rev_dn_m: got %b want 1", a_dnm); else passed++;
      a_act = 1'b0;
      step();
      a_act = 1'b1;
      step();
      total++; if (a_st !== 3'd4) $display("FAIL stop_dn_state: got %0d want 4", a_st); else passed++;
      total++; if (a_dnm !== 1'b0) $display("FAIL stop_dn_m: got %b want 0", a_dnm); else passed++;
      a_act = 1'b0;
      step();
      a_act = 1'b1;
      step();
      total++; if (a_upm !== 1'b1) $display("FAIL rev_up_m: got %b want 1", a_upm); else passed++;
      a_act = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      a_act = 1'b1;
      step();
      a_act = 1'b0; a_dn = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (a_upm === 1'b1) n++;
         else break;
         step();
      end
      total++; if (n !== 8) $display("FAIL timeout_up_cycles: got %0d want 8", n); else passed++;
      total++; if (a_flt !== 1'b1) $display("FAIL timeout_fault: got %b want 1", a_flt); else passed++;
      total++; if (a_st !== 3'd5) $display("FAIL timeout_state: got %0d want 5", a_st); else passed++;
      a_act = 1'b1;
      step();
      a_act = 1'b0;
      step();
      a_act = 1'b1;
      step();
      total++; if (a_st !== 3'd5) $display("FAIL fault_sticky_state: got %0d want 5", a_st); else passed++;
      total++; if ({a_upm, a_dnm} !== 2'b00) $display("FAIL fault_motors: got %b want 00", {a_upm, a_dnm}); else passed++;
      a_act = 1'b0;
      RST = 1'b0;
      #2;
      total++; if (a_flt !== 1'b0) $display("FAIL fault_cleared: got %b want 0", a_flt); else passed++;
   endtask

   task automatic test_auto_close();
      int k;
      do_reset();
      b_act = 1'b1;
      step();
      b_act = 1'b0; b_dn = 1'b0; b_up = 1'b1;
      step();
      total++; if (b_st !== 3'd3) $display("FAIL ac_open_state: got %0d want 3", b_st); else passed++;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (b_dnm === 1'b1) begin
            k = i;
            break;
         end
      end
      total++; if (k !== 5) $display("FAIL ac_delay: got %0d want 5", k); else passed++;
      do_reset();
      b_act = 1'b1;
      step();
      b_act = 1'b0; b_dn = 1'b0; b_up = 1'b1;
      step();
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (b_dnm === 1'b1 && k == 0) k = i;
         b_obs = (i <= 9);
      end
      b_obs = 1'b0;
      total++; if (k !== 15) $display("FAIL ac_obstacle_delay: got %0d want 15", k); else passed++;
   endtask

   task automatic test_sensor_fault();
      do_reset();
      a_up = 1'b1; a_dn = 1'b1;
      step();
      total++; if (a_flt !== 1'b1) $display("FAIL sensor_fault: got %b want 1", a_flt); else passed++;
      total++; if (a_st !== 3'd5) $display("FAIL sensor_state: got %0d want 5", a_st); else passed++;
      a_up = 1'b0;
   endtask

   task automatic test_reset_mid_travel();
      do_reset();
      a_up = 1'b1; a_dn = 1'b0; a_act = 1'b1;
      step();
      a_act = 1'b0; a_up = 1'b0;
      step();
      total++; if (a_dnm !== 1'b1) $display("FAIL mid_dn_m_on: got %b want 1", a_dnm); else passed++;
      RST = 1'b0;
      #2;
      total++; if (a_dnm !== 1'b0) $display("FAIL mid_reset_dn_m: got %b want 0", a_dnm); else passed++;
      total++; if (a_st !== 3'd0) $display("FAIL mid_reset_state: got %0d want 0", a_st); else passed++;
   endtask

   initial begin
      RST = 1'b0;
      test_reset();
      test_open_and_hold();
      test_obstacle();
      test_stop_reverse();
      test_timeout();
      test_auto_close();
      test_sensor_fault();
      test_reset_mid_travel();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
